// File: rtl/drive_pc_pkg.sv
// Shared definitions for the drive-circuit PC sequencer: channel state
// encodings and the default field widths of PC and loop-stack entries.
package drive_pc_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } ch_state_t;

    localparam int DEF_PC_WIDTH   = 11;
    localparam int DEF_NUM_CH     = 4;
    localparam int DEF_LOOP_WIDTH = 8;
    localparam int DEF_LOOP_DEPTH = 2;

endpackage

// File: rtl/drive_pc_ch.sv
// One drive channel: IDLE/RUN/DONE FSM, PC register and a small hardware
// loop stack holding {return address, remaining repeats} per nesting level.
module drive_pc_ch
    import drive_pc_pkg::*;
#(
    parameter int PC_WIDTH   = DEF_PC_WIDTH,
    parameter int LOOP_WIDTH = DEF_LOOP_WIDTH,
    parameter int LOOP_DEPTH = DEF_LOOP_DEPTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  update_pc,
    input  logic                  jump_en,
    input  logic [PC_WIDTH-1:0]   jump_addr,
    input  logic                  loop_push,
    input  logic [LOOP_WIDTH-1:0] loop_cnt,
    input  logic                  loop_end,
    input  logic                  halt,
    output logic [PC_WIDTH-1:0]   pc,
    output logic                  running,
    output logic                  done,
    output logic                  loop_err
);

    localparam int SPW = $clog2(LOOP_DEPTH + 1);
    localparam int IW  = (LOOP_DEPTH > 1) ? $clog2(LOOP_DEPTH) : 1;
    localparam logic [SPW-1:0] SP_FULL = SPW'(LOOP_DEPTH);

    ch_state_t             state_q, state_d;
    logic [PC_WIDTH-1:0]   pc_q, pc_d;
    logic [SPW-1:0]        sp_q, sp_d;
    logic                  err_q, err_d;
    logic [PC_WIDTH-1:0]   addr_q [LOOP_DEPTH];
    logic [PC_WIDTH-1:0]   addr_d [LOOP_DEPTH];
    logic [LOOP_WIDTH-1:0] cnt_q  [LOOP_DEPTH];
    logic [LOOP_WIDTH-1:0] cnt_d  [LOOP_DEPTH];

    logic [PC_WIDTH-1:0]   pc_inc;
    logic [IW-1:0]         top_idx;
    logic [IW-1:0]         push_idx;

    assign pc_inc   = pc_q + 1'b1;
    assign top_idx  = IW'(sp_q - 1'b1);
    assign push_idx = IW'(sp_q);

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        sp_d    = sp_q;
        err_d   = err_q;
        addr_d  = addr_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE: begin
                pc_d = '0;
                if (start) begin
                    state_d = ST_RUN;
                    sp_d    = '0;
                    err_d   = 1'b0;
                end
            end
            ST_RUN: begin
                if (update_pc) begin
                    if (halt) begin
                        state_d = ST_DONE;
                        sp_d    = '0;
                    end else begin
                        if (jump_en) begin
                            pc_d = jump_addr;
                        end else if (loop_end) begin
                            pc_d = pc_inc;
                            if (sp_q == '0) begin
                                err_d = 1'b1;
                            end else if (cnt_q[top_idx] != '0) begin
                                pc_d           = addr_q[top_idx];
                                cnt_d[top_idx] = cnt_q[top_idx] - 1'b1;
                            end else begin
                                sp_d = sp_q - 1'b1;
                            end
                        end else begin
                            pc_d = pc_inc;
                        end
                        // A push alongside loop_end would race the pop, so it is rejected.
                        if (loop_push) begin
                            if (loop_end || sp_q == SP_FULL) begin
                                err_d = 1'b1;
                            end else begin
                                addr_d[push_idx] = pc_inc;
                                cnt_d[push_idx]  = loop_cnt;
                                sp_d             = sp_q + 1'b1;
                            end
                        end
                    end
                end
            end
            ST_DONE: begin
                if (start) begin
                    state_d = ST_RUN;
                    pc_d    = '0;
                    sp_d    = '0;
                    err_d   = 1'b0;
                end
            end
            default: begin
                state_d = ST_IDLE;
                pc_d    = '0;
                sp_d    = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            pc_q    <= '0;
            sp_q    <= '0;
            err_q   <= 1'b0;
            for (int i = 0; i < LOOP_DEPTH; i++) begin
                addr_q[i] <= '0;
                cnt_q[i]  <= '0;
            end
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            sp_q    <= sp_d;
            err_q   <= err_d;
            addr_q  <= addr_d;
            cnt_q   <= cnt_d;
        end
    end

    assign pc       = pc_q;
    assign running  = (state_q == ST_RUN);
    assign done     = (state_q == ST_DONE);
    assign loop_err = err_q;

endmodule

// File: rtl/drive_pc_seq.sv
// Multi-channel PC sequencer: one independent drive_pc_ch per channel,
// with the packed buses sliced per channel.
module drive_pc_seq
    import drive_pc_pkg::*;
#(
    parameter int PC_WIDTH   = DEF_PC_WIDTH,
    parameter int NUM_CH     = DEF_NUM_CH,
    parameter int LOOP_WIDTH = DEF_LOOP_WIDTH,
    parameter int LOOP_DEPTH = DEF_LOOP_DEPTH
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [NUM_CH-1:0]            start,
    input  logic [NUM_CH-1:0]            update_pc,
    input  logic [NUM_CH-1:0]            jump_en,
    input  logic [NUM_CH*PC_WIDTH-1:0]   jump_addr,
    input  logic [NUM_CH-1:0]            loop_push,
    input  logic [NUM_CH*LOOP_WIDTH-1:0] loop_cnt,
    input  logic [NUM_CH-1:0]            loop_end,
    input  logic [NUM_CH-1:0]            halt,
    output logic [NUM_CH*PC_WIDTH-1:0]   PC,
    output logic [NUM_CH-1:0]            running,
    output logic [NUM_CH-1:0]            done,
    output logic [NUM_CH-1:0]            loop_err
);

    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
        drive_pc_ch #(
            .PC_WIDTH   (PC_WIDTH),
            .LOOP_WIDTH (LOOP_WIDTH),
            .LOOP_DEPTH (LOOP_DEPTH)
        ) u_ch (
            .clk       (clk),
            .rst       (rst),
            .start     (start[gi]),
            .update_pc (update_pc[gi]),
            .jump_en   (jump_en[gi]),
            .jump_addr (jump_addr[gi*PC_WIDTH +: PC_WIDTH]),
            .loop_push (loop_push[gi]),
            .loop_cnt  (loop_cnt[gi*LOOP_WIDTH +: LOOP_WIDTH]),
            .loop_end  (loop_end[gi]),
            .halt      (halt[gi]),
            .pc        (PC[gi*PC_WIDTH +: PC_WIDTH]),
            .running   (running[gi]),
            .done      (done[gi]),
            .loop_err  (loop_err[gi])
        );
    end

endmodule

// File: tb/tb_drive_pc_seq.sv
// Directed bench for drive_pc_seq: sequencing, stall, jump, loops, halt,
// channel independence, PC wrap and asynchronous reset.
module tb_drive_pc_seq;

    localparam int PW = 11;
    localparam int NC = 4;
    localparam int LW = 8;

    logic           clk = 1'b0;
    logic           rst;
    logic [NC-1:0]  start, upd, jmp, push, lend, hlt;
    logic [NC*PW-1:0] jaddr;
    logic [NC*LW-1:0] lcnt;
    logic [NC*PW-1:0] pc_bus;
    logic [NC-1:0]  running, done, loop_err;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    drive_pc_seq #(.PC_WIDTH(PW), .NUM_CH(NC), .LOOP_WIDTH(LW), .LOOP_DEPTH(2)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .update_pc (upd),
        .jump_en   (jmp),
        .jump_addr (jaddr),
        .loop_push (push),
        .loop_cnt  (lcnt),
        .loop_end  (lend),
        .halt      (hlt),
        .PC        (pc_bus),
        .running   (running),
        .done      (done),
        .loop_err  (loop_err)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [PW-1:0] pc_of(input int ch);
        return pc_bus[ch*PW +: PW];
    endfunction

    task automatic set_jaddr(input int ch, input int a);
        jaddr[ch*PW +: PW] = PW'(a);
    endtask

    task automatic set_lcnt(input int ch, input int c);
        lcnt[ch*LW +: LW] = LW'(c);
    endtask

    // Loop test program from PC=10: push cnt=2 at 10, loop_end at 12.
    int exp_loop [8] = '{10, 11, 12, 11, 12, 11, 12, 13};

    initial begin
        rst = 1'b0;
        start = '0; upd = '0; jmp = '0; push = '0; lend = '0; hlt = '0;
        jaddr = '0; lcnt = '0;
        repeat (3) tick();
        chk("reset_pc", pc_bus, 0);
        chk("reset_running", running, 0);
        chk("reset_done", done, 0);
        chk("reset_err", loop_err, 0);
        rst = 1'b1;
        tick();
        chk("idle_pc", pc_bus, 0);

        // Start channel 0 and step sequentially
        start[0] = 1'b1;
        tick();
        start[0] = 1'b0;
        chk("start_pc", pc_of(0), 0);
        chk("start_running", running, 4'b0001);
        upd[0] = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            tick();
            chk($sformatf("seq_pc%0d", i), pc_of(0), i);
        end
        upd[0] = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk($sformatf("stall_%0d", i), pc_of(0), 3);
        end
        upd[0] = 1'b1;
        tick(); chk("seq_pc4", pc_of(0), 4);
        tick(); chk("seq_pc5", pc_of(0), 5);

        // Jump
        jmp[0] = 1'b1; set_jaddr(0, 100);
        tick(); chk("jump_pc", pc_of(0), 100);
        jmp[0] = 1'b0;
        tick(); chk("jump_next", pc_of(0), 101);

        // Single loop, body 11..12 runs three times
        jmp[0] = 1'b1; set_jaddr(0, 10);
        tick(); chk("loop_pc0", pc_of(0), exp_loop[0]);
        jmp[0] = 1'b0;
        for (int i = 1; i < 8; i++) begin
            push[0] = (pc_of(0) == 10);
            set_lcnt(0, 2);
            lend[0] = (pc_of(0) == 12);
            tick();
            chk($sformatf("loop_pc%0d", i), pc_of(0), exp_loop[i]);
        end
        push[0] = 1'b0; lend[0] = 1'b0;
        chk("loop_err_clean", loop_err[0], 0);

        // Nested loops at 13 (outer cnt=1) and 14 (inner cnt=0), overflow push at 15
        push[0] = 1'b1; set_lcnt(0, 1);
        tick(); chk("nest_push1", pc_of(0), 14);
        set_lcnt(0, 0);
        tick(); chk("nest_push2", pc_of(0), 15);
        set_lcnt(0, 5);
        tick(); chk("nest_full_pc", pc_of(0), 16);
        chk("nest_full_err", loop_err[0], 1);
        push[0] = 1'b0; lend[0] = 1'b1;
        tick(); chk("nest_inner_pop", pc_of(0), 17);
        tick(); chk("nest_outer_back", pc_of(0), 14);
        lend[0] = 1'b0;
        tick(); tick(); tick();
        chk("nest_body", pc_of(0), 17);
        lend[0] = 1'b1;
        tick(); chk("nest_outer_pop", pc_of(0), 18);
        lend[0] = 1'b0;

        // Halt at 7, then restart clears error
        jmp[0] = 1'b1; set_jaddr(0, 7);
        tick(); chk("halt_addr", pc_of(0), 7);
        jmp[0] = 1'b0; hlt[0] = 1'b1;
        tick();
        hlt[0] = 1'b0;
        chk("halt_done", done[0], 1);
        chk("halt_running", running[0], 0);
        chk("halt_pc", pc_of(0), 7);
        tick(); chk("done_hold", pc_of(0), 7);
        start[0] = 1'b1;
        tick();
        start[0] = 1'b0;
        chk("restart_pc", pc_of(0), 0);
        chk("restart_running", running[0], 1);
        chk("restart_done", done[0], 0);
        chk("restart_err", loop_err[0], 0);
        lend[0] = 1'b1;
        tick();
        lend[0] = 1'b0;
        chk("empty_end_pc", pc_of(0), 1);
        chk("empty_end_err", loop_err[0], 1);
        upd[0] = 1'b0;

        // Channels 1 and 2 concurrently; channel 2 wraps at 2047
        start[2:1] = 2'b11;
        tick();
        start[2:1] = 2'b00;
        chk("multi_running", running, 4'b0111);
        upd[2:1] = 2'b11; jmp[2] = 1'b1; set_jaddr(2, 2047);
        tick();
        chk("multi_ch1", pc_of(1), 1);
        chk("multi_ch2", pc_of(2), 2047);
        chk("multi_ch0_hold", pc_of(0), 1);
        jmp[2] = 1'b0;
        tick();
        chk("wrap_ch2", pc_of(2), 0);
        chk("multi_ch1_b", pc_of(1), 2);
        chk("ch3_idle", {running[3], done[3], 11'(pc_of(3))}, 0);
        chk("ch1_err", loop_err[2:1], 0);

        // Push+end together on channel 1 rejects the push
        push[1] = 1'b1; lend[1] = 1'b1; set_lcnt(1, 3);
        tick();
        chk("pushend_pc", pc_of(1), 3);
        chk("pushend_err", loop_err[1], 1);
        lend[1] = 1'b0;
        tick(); chk("ch1_push", pc_of(1), 4);
        push[1] = 1'b0; lend[1] = 1'b1;
        tick(); chk("ch1_loopback", pc_of(1), 4);

        // Asynchronous reset mid-loop
        #2 rst = 1'b0;
        #1;
        chk("async_pc", pc_bus, 0);
        chk("async_running", running, 0);
        chk("async_done", done, 0);
        chk("async_err", loop_err, 0);
        upd = '0; lend = '0;
        tick();
        rst = 1'b1;
        tick();
        chk("post_reset_idle", running, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
